// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin burst arbiter for a shared FIFO write port,
// with high/low watermark hysteresis on the FIFO occupancy.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned HI_MARK   = 5,
  parameter int unsigned LO_MARK   = 2,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic [CNT_W-1:0]  fifo_words_i,
  output logic              fifo_wr_en_o,
  output logic [DATA_W-1:0] fifo_data_o,
  output logic [1:0]        grant_o,
  output logic              throttled_o
);

  localparam int unsigned BeatW = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] HiMark   = CNT_W'(HI_MARK);
  localparam logic [CNT_W-1:0] LoMark   = CNT_W'(LO_MARK);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [BeatW-1:0] beat_q, beat_d;

  logic owner_valid;
  logic hi_reached;
  logic lo_reached;

  assign owner_valid = owner_q ? req1_valid_i : req0_valid_i;
  assign hi_reached  = (fifo_words_i >= HiMark);
  assign lo_reached  = (fifo_words_i <= LoMark);

  always_comb begin
    fifo_wr_en_o = (state_q == StBurst) && owner_valid;
    req0_ready_o = fifo_wr_en_o && !owner_q;
    req1_ready_o = fifo_wr_en_o && owner_q;
    fifo_data_o  = '0;
    if (fifo_wr_en_o) begin
      fifo_data_o = owner_q ? req1_data_i : req0_data_i;
    end
    grant_o = 2'b00;
    if (state_q == StBurst) begin
      grant_o = owner_q ? 2'b10 : 2'b01;
    end
    throttled_o = (state_q == StDrain);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    unique case (state_q)
      StIdle: begin
        beat_d = '0;
        if (hi_reached) begin
          state_d = StDrain;
        end else if (req0_valid_i ^ req1_valid_i) begin
          owner_d = req1_valid_i;
          state_d = StBurst;
        end else if (req0_valid_i && req1_valid_i) begin
          owner_d = !last_owner_q;
          state_d = StBurst;
        end
      end
      StBurst: begin
        // A write in the same cycle as the watermark hit still completes.
        if (hi_reached) begin
          state_d      = StDrain;
          last_owner_d = owner_q;
        end else if (fifo_wr_en_o && (beat_q == LastBeat)) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end else if (!owner_valid) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      StDrain: begin
        if (lo_reached) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench: per-cycle expected outputs are queued by the stimulus
// thread and compared by an independent negedge monitor.
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic [3:0] fifo_words = 4'd0;
  logic       fifo_wr_en;
  logic [7:0] fifo_data;
  logic [1:0] grant;
  logic       throttled;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [13:0] exp;
  } sb_t;

  sb_t sb_q[$];
  string phase = "reset";
  int    vec = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_W(8), .CNT_W(4), .HI_MARK(5), .LO_MARK(2), .BURST_LEN(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req0_valid_i (req0_valid),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .fifo_words_i (fifo_words),
    .fifo_wr_en_o (fifo_wr_en),
    .fifo_data_o  (fifo_data),
    .grant_o      (grant),
    .throttled_o  (throttled)
  );

  // Packed view: {wr_en, ready0, ready1, grant, data, throttled}
  function automatic logic [13:0] pack_out();
    return {fifo_wr_en, req0_ready, req1_ready, grant, fifo_data, throttled};
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      logic [13:0] act;
      e = sb_q.pop_front();
      act = pack_out();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got we=%b r0=%b r1=%b g=%b d=%h thr=%b, want we=%b r0=%b r1=%b g=%b d=%h thr=%b",
                 e.tag, act[13], act[12], act[11], act[10:9], act[8:1], act[0],
                 e.exp[13], e.exp[12], e.exp[11], e.exp[10:9], e.exp[8:1], e.exp[0]);
      end
    end
  end

  task automatic cyc(input logic rst, input logic v0, input logic v1, input logic [3:0] w,
                     input logic we, input logic [1:0] g, input logic thr);
    sb_t e;
    logic [7:0] d;
    @(posedge clk);
    #1;
    rst_n      = rst;
    req0_valid = v0;
    req1_valid = v1;
    fifo_words = w;
    d = we ? ((g == 2'b10) ? req1_data : req0_data) : 8'h00;
    e.tag = $sformatf("%s#%0d", phase, vec);
    e.exp = {we, we && (g == 2'b01), we && (g == 2'b10), g, d, thr};
    sb_q.push_back(e);
    vec++;
  endtask

  initial begin
    req0_data = 8'hAA;
    req1_data = 8'h55;

    // Reset held with both requesters valid.
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);

    // Round robin: req0 first after reset, bursts of 4 with one IDLE gap.
    phase = "rr";
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 2'b10, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);

    // Gap release: owner valid drops, grant passes to req1.
    phase = "gap";
    req0_data = 8'h3C;
    req1_data = 8'hC3;
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 2'b10, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b10, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);

    // Hysteresis: count follows expected writes with one cycle lag, then drains.
    phase = "hyst";
    req0_data = 8'hAA;
    req1_data = 8'h55;
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 2'b00, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);

    // Mid-burst reset on the second write of a req1 burst.
    phase = "mrst";
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 2'b10, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 2'b10, 1'b0);
    #6;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pack_out() !== 14'd0) begin
      errors++;
      $display("FAIL mrst_async: got outputs=%b, want %b", pack_out(), 14'd0);
    end
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
